aud_serializer_i2s: RTL and testbench
=====================================

AUD_SERIALIZER_I2S -- requirements
Module: aud_serializer_i2s

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits (legal 8..32).
REQ-002 SHALL have parameter VOL_W, default 3, width of each per-channel attenuation code.
REQ-003 SHALL have one clock and an asynchronous active-low reset: i_bclk, the only clock, and i_rst_n, the reset.
REQ-004 Ports, one per line: name  direction  width  meaning.
- i_bclk  in  1  bit clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_daclrck  in  1  word clock; low = left slot, high = right slot.
- i_en  in  1  playback enable.
- i_valid  in  1  stereo sample pair available.
- i_data_l  in  DATA_W  signed left sample.
- i_data_r  in  DATA_W  signed right sample.
- i_vol_l, i_vol_r  in  VOL_W  arithmetic right-shift amount per channel.
- i_mute_l, i_mute_r  in  1  force channel to zero.
- o_ready  out  1  one-cycle pulse: pair consumed this cycle.
- o_aud_dacdat  out  1  serial DAC data, registered.
- o_underrun  out  1  sticky: frame started without a valid pair.
- o_frame_err  out  1  sticky: slot ended before DATA_W bits were sent.
- o_state  out  2  current FSM state encoding.

Function
REQ-005 SHALL register i_daclrck into lrck_q every cycle; falling edge = (lrck_q=1, i_daclrck=0); rising edge = (lrck_q=0, i_daclrck=1).
REQ-006 SHALL implement FSM WAIT=0, IDLE=1, LEFT=2, RIGHT=3.
REQ-007 WAIT -> IDLE when i_en=1 and i_daclrck=1; otherwise stay.
REQ-008 IDLE -> LEFT on falling edge with i_en=1.
REQ-009 LEFT -> RIGHT on rising edge; RIGHT -> LEFT on falling edge (continuous frames, no IDLE pass).
REQ-010 Any state -> WAIT in the cycle after i_en samples 0; i_en takes priority over all edges.
REQ-011 On every falling edge accepted in IDLE or RIGHT: if i_valid=1, pulse o_ready and latch both channels; else latch zero pair and set o_underrun.
REQ-012 Latched channel value SHALL be 0 if mute; else sign-extended i_data >>> i_vol (arithmetic), result truncated to DATA_W; shift >= DATA_W yields all sign bits.
REQ-013 Left word MSB SHALL appear on o_aud_dacdat in the cycle after the falling edge is detected; remaining bits follow MSB-first, one per cycle.
REQ-014 Right word SHALL be sent likewise starting the cycle after the rising edge.
REQ-015 After DATA_W bits in a slot, o_aud_dacdat SHALL be 0 until the next slot edge.
REQ-016 A slot edge arriving before DATA_W bits were sent SHALL abort the word, start the new slot per REQ-013/014, and set o_frame_err.
REQ-017 Bit counter SHALL be ceil(log2(DATA_W+1)) wide and saturate at DATA_W; it SHALL NOT wrap.
REQ-018 In WAIT and IDLE, o_aud_dacdat SHALL be 0 and o_ready SHALL be 0.
REQ-019 o_underrun and o_frame_err SHALL clear on reset and on WAIT -> IDLE transition only.
REQ-020 i_vol/i_mute changes SHALL take effect only at the next latch (REQ-011), never mid-word.

Reset
REQ-021 On i_rst_n=0, immediately: state=WAIT, o_aud_dacdat=0, o_ready=0, o_underrun=0, o_frame_err=0, counter=0, lrck_q=0, shift registers=0.
REQ-022 Reset mid-word SHALL abandon the word; after release, output resumes only via REQ-007/008.

Verification (DATA_W=16, VOL_W=3, 32-bclk slots)
REQ-023 i_en=1, i_valid=1, L=0x8001, R=0x7FFE, vol=0 -> o_ready pulse at left edge; left bits 1000000000000001, 16 zeros, right 0111111111111110, 16 zeros.
REQ-024 L=0x8000, i_vol_l=2; R=0x4000, i_mute_r=1 -> left word 0xE000, right word 0x0000.
REQ-025 i_valid=0 at falling edge -> both words 0x0000, o_ready stays 0, o_underrun=1 and stays 1 after i_valid returns.
REQ-026 8-bclk slots -> only 8 MSBs sent per slot, o_frame_err=1, next slot starts on time.
REQ-027 i_en drops mid left word -> o_aud_dacdat=0 next cycle, state=WAIT; i_en re-raised while lrck low -> stays WAIT until lrck high, then first output at next falling edge, flags cleared.
REQ-028 i_rst_n pulsed mid right word -> all outputs 0 within the reset, state=WAIT.

Source files
------------

// File: rtl/aud_serializer_i2s.sv
// I2S-style DAC serializer: latches a stereo pair at each left-slot start and
// shifts each channel out MSB-first, with per-channel attenuation and mute.
module aud_serializer_i2s #(
  parameter int DATA_W = 16,
  parameter int VOL_W  = 3
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data_l,
  input  logic [DATA_W-1:0] i_data_r,
  input  logic [VOL_W-1:0]  i_vol_l,
  input  logic [VOL_W-1:0]  i_vol_r,
  input  logic              i_mute_l,
  input  logic              i_mute_r,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic              o_underrun,
  output logic              o_frame_err,
  output logic [1:0]        o_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LEFT  = 2'd2,
    ST_RIGHT = 2'd3
  } state_t;

  state_t                   state, next_state;
  logic                     lrck_q;
  logic                     fall, rise;
  logic                     accept_fall, accept_rise;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_W-1:0]        shreg;
  logic [DATA_W-1:0]        hold_r;
  logic signed [DATA_W-1:0] shifted_l, shifted_r;
  logic [DATA_W-1:0]        word_l, word_r;

  assign fall = lrck_q & ~i_daclrck;
  assign rise = ~lrck_q & i_daclrck;

  assign accept_fall = i_en & fall & ((state == ST_IDLE) | (state == ST_RIGHT));
  assign accept_rise = i_en & rise & (state == ST_LEFT);

  // Arithmetic shift keeps the sign, so large attenuation saturates to all sign bits.
  always_comb begin
    shifted_l = $signed(i_data_l) >>> i_vol_l;
    shifted_r = $signed(i_data_r) >>> i_vol_r;
    word_l    = i_mute_l ? '0 : shifted_l;
    word_r    = i_mute_r ? '0 : shifted_r;
  end

  always_comb begin
    next_state = state;
    if (!i_en) begin
      next_state = ST_WAIT;
    end else begin
      case (state)
        ST_WAIT:  if (i_daclrck) next_state = ST_IDLE;
        ST_IDLE:  if (fall)      next_state = ST_LEFT;
        ST_LEFT:  if (rise)      next_state = ST_RIGHT;
        ST_RIGHT: if (fall)      next_state = ST_LEFT;
        default:                 next_state = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_WAIT;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_q       <= 1'b0;
      o_ready      <= 1'b0;
      o_aud_dacdat <= 1'b0;
      o_underrun   <= 1'b0;
      o_frame_err  <= 1'b0;
      cnt          <= '0;
      shreg        <= '0;
      hold_r       <= '0;
    end else begin
      lrck_q  <= i_daclrck;
      o_ready <= accept_fall & i_valid;
      if ((state == ST_WAIT) && (next_state == ST_IDLE)) begin
        o_underrun  <= 1'b0;
        o_frame_err <= 1'b0;
      end
      if (!i_en) begin
        o_aud_dacdat <= 1'b0;
        cnt          <= '0;
      end else if (accept_fall) begin
        // The right word is captured here too, so mid-frame input changes are ignored.
        if ((state == ST_RIGHT) && (cnt != CNT_FULL)) o_frame_err <= 1'b1;
        if (!i_valid) o_underrun <= 1'b1;
        o_aud_dacdat <= i_valid ? word_l[DATA_W-1] : 1'b0;
        shreg        <= i_valid ? (word_l << 1) : '0;
        hold_r       <= i_valid ? word_r : '0;
        cnt          <= CNT_W'(1);
      end else if (accept_rise) begin
        if (cnt != CNT_FULL) o_frame_err <= 1'b1;
        o_aud_dacdat <= hold_r[DATA_W-1];
        shreg        <= hold_r << 1;
        cnt          <= CNT_W'(1);
      end else if (((state == ST_LEFT) || (state == ST_RIGHT)) && (cnt != CNT_FULL)) begin
        o_aud_dacdat <= shreg[DATA_W-1];
        shreg        <= shreg << 1;
        cnt          <= cnt + CNT_W'(1);
      end else begin
        o_aud_dacdat <= 1'b0;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_aud_serializer_i2s.sv
// Scoreboard bench for aud_serializer_i2s: the driver queues the expected slot
// contents from an arithmetic model and a negedge monitor collects and compares.
module tb_aud_serializer_i2s;

  localparam int DATA_W = 16;
  localparam int VOL_W  = 3;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          len;
    bit          ready;
  } slot_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              daclrck;
  logic              en;
  logic              valid;
  logic [DATA_W-1:0] data_l, data_r;
  logic [VOL_W-1:0]  vol_l, vol_r;
  logic              mute_l, mute_r;
  logic              ready;
  logic              dacdat;
  logic              underrun;
  logic              frame_err;
  logic [1:0]        state;

  int    n_checks = 0;
  int    n_fail   = 0;
  slot_t sb[$];

  always #5 clk = ~clk;

  aud_serializer_i2s #(.DATA_W(DATA_W), .VOL_W(VOL_W)) dut (
    .i_bclk      (clk),
    .i_rst_n     (rst_n),
    .i_daclrck   (daclrck),
    .i_en        (en),
    .i_valid     (valid),
    .i_data_l    (data_l),
    .i_data_r    (data_r),
    .i_vol_l     (vol_l),
    .i_vol_r     (vol_r),
    .i_mute_l    (mute_l),
    .i_mute_r    (mute_r),
    .o_ready     (ready),
    .o_aud_dacdat(dacdat),
    .o_underrun  (underrun),
    .o_frame_err (frame_err),
    .o_state     (state)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Attenuation as floor division by a power of two on the signed sample value.
  function automatic logic [15:0] model_word(input logic [15:0] d, input int vol, input bit mute);
    int v, p, q;
    if (mute) return 16'h0000;
    v = d[15] ? int'(d) - 65536 : int'(d);
    p = 1 << vol;
    q = (v >= 0) ? v / p : -((-v + p - 1) / p);
    return q[15:0];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    valid  = 1'($urandom);
    data_l = 16'($urandom);
    data_r = 16'($urandom);
    vol_l  = 3'($urandom);
    vol_r  = 3'($urandom);
    mute_l = 1'($urandom);
    mute_r = 1'($urandom);
  endtask

  // Drives one stereo frame; must be entered at posedge+1.
  task automatic apply_stimulus(input int len, input bit v, input logic [15:0] l, input logic [15:0] r,
                                input int vl, input int vr, input bit ml, input bit mr);
    slot_t s;
    daclrck = 1'b0;
    valid   = v;
    data_l  = l;
    data_r  = r;
    vol_l   = vl[2:0];
    vol_r   = vr[2:0];
    mute_l  = ml;
    mute_r  = mr;
    s.word  = v ? model_word(l, vl, ml) : 16'h0000;
    s.nbits = (len < DATA_W) ? len : DATA_W;
    s.len   = len;
    s.ready = v;
    sb.push_back(s);
    wait_cycles(1);
    scramble_inputs();
    wait_cycles(len - 1);
    daclrck = 1'b1;
    s.word  = v ? model_word(r, vr, mr) : 16'h0000;
    s.ready = 1'b0;
    sb.push_back(s);
    scramble_inputs();
    wait_cycles(len);
  endtask

  task automatic random_frame(input int len);
    apply_stimulus(len, 1'b1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
  endtask

  slot_t       cur;
  bit          armed      = 1'b0;
  bit          collecting = 1'b0;
  int          idx;
  logic [31:0] got, expv;
  logic        prev_lrck  = 1'b1;

  // A slot's first bit appears two negedges after the bench changes the word clock.
  always @(negedge clk) begin
    if (armed) begin
      cur        = sb.pop_front();
      collecting = 1'b1;
      idx        = 0;
      got        = '0;
      armed      = 1'b0;
    end
    if (collecting) begin
      got = {got[30:0], dacdat};
      if (idx == 0) check_output("ready_pulse", 32'(ready), 32'(cur.ready));
      if (idx == 1) check_output("ready_single", 32'(ready), 32'd0);
      idx++;
      if (idx == cur.len) begin
        expv = '0;
        for (int i = 0; i < cur.len; i++)
          expv = {expv[30:0], (i < cur.nbits) ? cur.word[15-i] : 1'b0};
        check_output("slot_bits", got, expv);
        collecting = 1'b0;
      end
    end
    if ((daclrck !== prev_lrck) && (sb.size() > 0)) armed = 1'b1;
    prev_lrck = daclrck;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    daclrck = 1'b1;
    valid   = 1'b0;
    data_l  = '0;
    data_r  = '0;
    vol_l   = '0;
    vol_r   = '0;
    mute_l  = 1'b0;
    mute_r  = 1'b0;
    #12;
    check_output("reset_state", 32'(state), 32'd0);
    check_output("reset_dacdat", 32'(dacdat), 32'd0);
    check_output("reset_ready", 32'(ready), 32'd0);
    check_output("reset_underrun", 32'(underrun), 32'd0);
    check_output("reset_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b1;
    wait_cycles(3);
    check_output("wait_to_idle", 32'(state), 32'd1);

    apply_stimulus(32, 1'b1, 16'h8001, 16'h7FFE, 0, 0, 1'b0, 1'b0);
    apply_stimulus(32, 1'b1, 16'h8000, 16'h4000, 2, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) random_frame(32);
    check_output("no_underrun", 32'(underrun), 32'd0);
    check_output("no_frame_err", 32'(frame_err), 32'd0);

    apply_stimulus(32, 1'b0, 16'h1234, 16'h5678, 0, 0, 1'b0, 1'b0);
    random_frame(32);
    check_output("underrun_sticky", 32'(underrun), 32'd1);
    check_output("frame_err_clear", 32'(frame_err), 32'd0);

    random_frame(8);
    random_frame(8);
    check_output("frame_err_set", 32'(frame_err), 32'd1);
    random_frame(32);

    // Enable drop in the middle of a left word, then re-arm while the word clock is low.
    daclrck = 1'b0;
    wait_cycles(5);
    en = 1'b0;
    wait_cycles(1);
    check_output("en_drop_dacdat", 32'(dacdat), 32'd0);
    check_output("en_drop_state", 32'(state), 32'd0);
    wait_cycles(4);
    en = 1'b1;
    wait_cycles(4);
    check_output("rearm_low_state", 32'(state), 32'd0);
    check_output("rearm_low_underrun", 32'(underrun), 32'd1);
    check_output("rearm_low_dacdat", 32'(dacdat), 32'd0);
    daclrck = 1'b1;
    wait_cycles(1);
    check_output("rearm_high_state", 32'(state), 32'd1);
    check_output("rearm_underrun_clr", 32'(underrun), 32'd0);
    check_output("rearm_frame_err_clr", 32'(frame_err), 32'd0);
    wait_cycles(3);
    random_frame(32);

    // Reset pulse in the middle of a right word.
    begin
      slot_t s;
      daclrck = 1'b0;
      valid   = 1'b1;
      data_l  = 16'hA5C3;
      data_r  = 16'h3C5A;
      vol_l   = 3'd1;
      vol_r   = 3'd0;
      mute_l  = 1'b0;
      mute_r  = 1'b0;
      s.word  = model_word(16'hA5C3, 1, 1'b0);
      s.nbits = DATA_W;
      s.len   = 32;
      s.ready = 1'b1;
      sb.push_back(s);
      wait_cycles(32);
      daclrck = 1'b1;
      wait_cycles(6);
      rst_n = 1'b0;
      #1;
      check_output("midword_rst_dacdat", 32'(dacdat), 32'd0);
      check_output("midword_rst_ready", 32'(ready), 32'd0);
      check_output("midword_rst_state", 32'(state), 32'd0);
      check_output("midword_rst_underrun", 32'(underrun), 32'd0);
      check_output("midword_rst_frame_err", 32'(frame_err), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      wait_cycles(2);
      check_output("post_rst_state", 32'(state), 32'd1);
      check_output("post_rst_dacdat", 32'(dacdat), 32'd0);
    end
    random_frame(32);
    random_frame(32);

    wait_cycles(40);
    check_output("scoreboard_drained", 32'(sb.size() + int'(collecting) + int'(armed)), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
